// File: rtl/md_unit.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | md_unit: multi-cycle mult/div unit with HI/LO and Busy for EX stalling. |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] Operand1,
  input  logic [31:0] Operand2,
  input  logic [2:0]  MDOp,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  localparam logic [CW-1:0] C_MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] C_DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] C_ONE    = CW'(1);

  localparam logic [2:0] C_OP_MULT  = 3'b001;
  localparam logic [2:0] C_OP_MULTU = 3'b010;
  localparam logic [2:0] C_OP_DIV   = 3'b011;
  localparam logic [2:0] C_OP_DIVU  = 3'b100;
  localparam logic [2:0] C_OP_MTHI  = 3'b101;
  localparam logic [2:0] C_OP_MTLO  = 3'b110;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   phi_q, phi_d;
  logic [31:0]   plo_q, plo_d;

  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  logic signed [31:0] w_quot_s, w_rem_s;
  logic        [31:0] w_quot_u, w_rem_u;
  logic               w_div_zero;
  logic               w_div_ovf;

  // Results are formed combinationally and parked in the pending regs at start.
  always_comb begin
    w_prod_s   = {{32{Operand1[31]}}, Operand1} * {{32{Operand2[31]}}, Operand2};
    w_prod_u   = {32'd0, Operand1} * {32'd0, Operand2};
    w_div_zero = (Operand2 == 32'd0);
    w_div_ovf  = (Operand1 == 32'h8000_0000) && (Operand2 == 32'hFFFF_FFFF);
    w_quot_s   = 32'sd0;
    w_rem_s    = 32'sd0;
    w_quot_u   = 32'd0;
    w_rem_u    = 32'd0;
    if (w_div_zero) begin
      w_quot_s = 32'shFFFF_FFFF;
      w_rem_s  = $signed(Operand1);
      w_quot_u = 32'hFFFF_FFFF;
      w_rem_u  = Operand1;
    end else begin
      w_quot_u = Operand1 / Operand2;
      w_rem_u  = Operand1 % Operand2;
      if (w_div_ovf) begin
        w_quot_s = 32'sh8000_0000;
        w_rem_s  = 32'sd0;
      end else begin
        w_quot_s = $signed(Operand1) / $signed(Operand2);
        w_rem_s  = $signed(Operand1) % $signed(Operand2);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    unique case (state_q)
      ST_IDLE: begin
        case (MDOp)
          C_OP_MULT: begin
            {phi_d, plo_d} = w_prod_s;
            cnt_d          = C_MULT_N;
            state_d        = ST_RUN;
          end
          C_OP_MULTU: begin
            {phi_d, plo_d} = w_prod_u;
            cnt_d          = C_MULT_N;
            state_d        = ST_RUN;
          end
          C_OP_DIV: begin
            phi_d   = w_rem_s;
            plo_d   = w_quot_s;
            cnt_d   = C_DIV_N;
            state_d = ST_RUN;
          end
          C_OP_DIVU: begin
            phi_d   = w_rem_u;
            plo_d   = w_quot_u;
            cnt_d   = C_DIV_N;
            state_d = ST_RUN;
          end
          C_OP_MTHI: hi_d = Operand1;
          C_OP_MTLO: lo_d = Operand1;
          default: ;
        endcase
      end
      ST_RUN: begin
        // MDOp is deliberately ignored here; only the countdown matters.
        cnt_d = cnt_q - C_ONE;
        if (cnt_q == C_ONE) begin
          hi_d    = phi_q;
          lo_d    = plo_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end

  assign Busy = (state_q == ST_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_md_unit: directed vectors for md_unit timing and HI/LO results.      |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module tb_md_unit;

  logic        clk;
  logic        reset_n;
  logic [31:0] Operand1;
  logic [31:0] Operand2;
  logic [2:0]  MDOp;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks   = 0;
  int failures = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .MDOp     (MDOp),
    .Busy     (Busy),
    .HI       (HI),
    .LO       (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Issue op at one edge, then count Busy cycles sampled on falling edges.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    MDOp = op; Operand1 = a; Operand2 = b;
    @(negedge clk);
    MDOp = 3'b000; Operand1 = 32'hDEAD_BEEF; Operand2 = 32'h0BAD_F00D;
    cyc = 0;
    while (Busy && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(cyc), 32'(n));
    check({tag, "_hi"}, HI, exp_hi);
    check({tag, "_lo"}, LO, exp_lo);
  endtask

  initial begin
    int cyc;
    reset_n = 1'b1; MDOp = 3'b000; Operand1 = 32'h1111_1111; Operand2 = 32'h2222_2222;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    repeat (5) @(negedge clk);
    check("idle_busy", {31'd0, Busy}, 32'd0);
    check("idle_hi", HI, 32'd0);
    check("idle_lo", LO, 32'd0);

    run_op("mult_neg",  3'b001, 32'h8000_0000, 32'h0000_0002, 5,  32'hFFFF_FFFF, 32'h0000_0000);
    run_op("multu",     3'b010, 32'h8000_0000, 32'h0000_0002, 5,  32'h0000_0001, 32'h0000_0000);
    run_op("mult_mix",  3'b001, 32'hFFFF_FFFD, 32'h0000_0007, 5,  32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div_neg",   3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",      3'b100, 32'h0000_0007, 32'h0000_0002, 10, 32'h0000_0001, 32'h0000_0003);
    run_op("divu_zero", 3'b100, 32'h0000_1234, 32'h0000_0000, 10, 32'h0000_1234, 32'hFFFF_FFFF);
    run_op("div_zero",  3'b011, 32'hFFFF_FF00, 32'h0000_0000, 10, 32'hFFFF_FF00, 32'hFFFF_FFFF);
    run_op("div_ovf",   3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_big",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h8000_0000, 32'h0000_0000);

    // mtlo during a running mult must be dropped; HI/LO hold until completion.
    MDOp = 3'b001; Operand1 = 32'd3; Operand2 = 32'd4;
    @(negedge clk);
    MDOp = 3'b000;
    @(negedge clk);
    MDOp = 3'b110; Operand1 = 32'h0000_00AA;
    check("run_hold_lo", LO, 32'h0000_0000);
    check("run_hold_hi", HI, 32'h8000_0000);
    @(negedge clk);
    MDOp = 3'b000;
    check("run_busy", {31'd0, Busy}, 32'd1);
    check("run_lo_after_mtlo", LO, 32'h0000_0000);
    cyc = 0;
    while (Busy && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    check("mult_ign_cycles_left", 32'(cyc), 32'd3);
    check("mult_ign_hi", HI, 32'h0000_0000);
    check("mult_ign_lo", LO, 32'h0000_000C);

    MDOp = 3'b101; Operand1 = 32'h0000_0055;
    @(negedge clk);
    MDOp = 3'b000;
    check("mthi_hi", HI, 32'h0000_0055);
    check("mthi_lo", LO, 32'h0000_000C);
    check("mthi_busy", {31'd0, Busy}, 32'd0);
    MDOp = 3'b110; Operand1 = 32'h0000_0077;
    @(negedge clk);
    MDOp = 3'b000;
    check("mtlo_lo", LO, 32'h0000_0077);
    check("mtlo_hi", HI, 32'h0000_0055);
    MDOp = 3'b111; Operand1 = 32'h1234_5678;
    @(negedge clk);
    MDOp = 3'b000;
    check("nop7_hi", HI, 32'h0000_0055);
    check("nop7_lo", LO, 32'h0000_0077);
    check("nop7_busy", {31'd0, Busy}, 32'd0);

    // Reset in the 4th Busy cycle of a divide aborts it with no late write-back.
    MDOp = 3'b011; Operand1 = 32'd100; Operand2 = 32'd7;
    @(negedge clk);
    MDOp = 3'b000;
    repeat (3) @(negedge clk);
    check("abort_busy_before", {31'd0, Busy}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    repeat (12) @(negedge clk);
    check("abort_late_busy", {31'd0, Busy}, 32'd0);
    check("abort_late_hi", HI, 32'd0);
    check("abort_late_lo", LO, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
